// File: rtl/run_sequencer_pkg.sv
// Shared definitions for the run sequencer: state encodings, memory timeout
// length and counter widths.
package run_sequencer_pkg;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t FETCH = 3'd1;
    localparam state_t EXEC  = 3'd2;
    localparam state_t MEM   = 3'd3;
    localparam state_t HALT  = 3'd4;

    // Number of consecutive not-ready MEM cycles tolerated before giving up.
    localparam int kMemTimeout = 16;
    localparam int TIMEOUT_W   = $clog2(kMemTimeout);

    localparam int COUNT_W = 16;

endpackage

// File: rtl/run_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter
    import run_sequencer_pkg::*;
#(
    parameter int WIDTH = COUNT_W
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // Clear wins over enable; increment stops once every bit is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Control sequencer for a small processor: steps fetch / execute / memory
// phases, issues PC and enable strobes, and reports run status.
module run_sequencer
    import run_sequencer_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Ack,
    input  logic               LoadInst,
    input  logic               StoreInst,
    input  logic               JumpEqual,
    input  logic               JumpNotEqual,
    input  logic               EqFlag,
    input  logic               RegWrEnIn,
    input  logic               MemReady,
    output logic               PcInit,
    output logic               PcAdvance,
    output logic               PcBranch,
    output logic               IrLoad,
    output logic               RegWrEn,
    output logic               MemRdEn,
    output logic               MemWrEn,
    output logic               Busy,
    output logic               Done,
    output logic               Error,
    output logic [COUNT_W-1:0] CycleCount
);

    state_t               state;
    state_t               state_next;
    logic [TIMEOUT_W-1:0] mem_wait;
    logic                 error_q;
    logic                 timeout_hit;
    logic                 branch_taken;

    assign branch_taken = (JumpEqual && EqFlag) || (JumpNotEqual && !EqFlag);
    // Last tolerated not-ready cycle of a memory access.
    assign timeout_hit  = (state == MEM) && !MemReady &&
                          (mem_wait == TIMEOUT_W'(kMemTimeout - 1));
    assign Error        = error_q;

    // Next-state and strobe decode; decoder flags only matter in EXEC and MEM.
    always_comb begin
        state_next = state;
        PcInit     = 1'b0;
        PcAdvance  = 1'b0;
        PcBranch   = 1'b0;
        IrLoad     = 1'b0;
        RegWrEn    = 1'b0;
        MemRdEn    = 1'b0;
        MemWrEn    = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE, HALT: begin
                Done = (state == HALT);
                // Gated with Reset so a held Start cannot strobe during reset.
                if (Start && Reset) begin
                    PcInit     = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                Busy       = 1'b1;
                IrLoad     = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                Busy = 1'b1;
                if (Ack) begin
                    state_next = HALT;
                end else if (LoadInst || StoreInst) begin
                    state_next = MEM;
                end else begin
                    RegWrEn    = RegWrEnIn;
                    PcBranch   = branch_taken;
                    PcAdvance  = !branch_taken;
                    state_next = FETCH;
                end
            end
            MEM: begin
                Busy = 1'b1;
                // Enables stay up through the final cycle, including the one
                // in which the timeout fires; they drop once HALT is entered.
                MemRdEn = LoadInst;
                MemWrEn = StoreInst;
                if (MemReady) begin
                    RegWrEn    = LoadInst;
                    PcAdvance  = 1'b1;
                    state_next = FETCH;
                end else if (timeout_hit) begin
                    state_next = HALT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counts consecutive not-ready MEM cycles; rearmed in every EXEC.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mem_wait <= '0;
        end else if (state == EXEC) begin
            mem_wait <= '0;
        end else if ((state == MEM) && !MemReady) begin
            mem_wait <= mem_wait + 1'b1;
        end
    end

    // Sticky error flag: set by a memory timeout, cleared by a new run.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            error_q <= 1'b0;
        end else if (PcInit) begin
            error_q <= 1'b0;
        end else if (timeout_hit) begin
            error_q <= 1'b1;
        end
    end

    sat_counter #(
        .WIDTH (COUNT_W)
    ) u_cycle_count (
        .clk    (Clk),
        .rst_n  (Reset),
        .clear  (PcInit),
        .enable (Busy),
        .count  (CycleCount)
    );

endmodule
